// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB bus arbiter: fixed-priority or round-robin grant with burst, lock and split handling.
// Optional split masking is compiled in when AHB_ARB_SPLIT_EN is defined.
module ahb_arbiter_param #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int ARB_MODE       = 1,
    localparam int MW            = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [NO_OF_MASTERS-1:0] HSPLIT,
    input  logic                     HREADY,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic [1:0]               HRESP,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]            HMASTER,
    output logic                     HMASTLOCK
);

    localparam logic [MW-1:0]            DEF_IDX    = MW'(DEFAULT_MASTER);
    localparam logic [NO_OF_MASTERS-1:0] DEF_ONEHOT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

    logic [NO_OF_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]            hmaster_q;
    logic                     hmastlock_q;
    logic [MW-1:0]            rr_ptr_q;
    logic [3:0]               beats_left_q, beats_left_d;
    logic [NO_OF_MASTERS-1:0] split_mask_q;
    logic [NO_OF_MASTERS-1:0] elig_s;
    logic [MW-1:0]            grant_idx_s;
    logic [MW-1:0]            win_idx_s;
    logic                     found_s;
    logic                     hold_s;
    logic                     rearb_s;

    function automatic logic [MW-1:0] onehot_to_idx(input logic [NO_OF_MASTERS-1:0] v);
        logic [MW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (v[i]) begin
                idx = idx | MW'(i);
            end
        end
        return idx;
    endfunction

    assign grant_idx_s = onehot_to_idx(grant_q);
    assign elig_s      = HBUSREQ & ~split_mask_q;

    // Winner selection: lowest index, or first eligible after rr_ptr in round-robin order.
    always_comb begin
        win_idx_s = DEF_IDX;
        found_s   = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NO_OF_MASTERS; i++) begin
                if (!found_s && elig_s[i]) begin
                    win_idx_s = MW'(i);
                    found_s   = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NO_OF_MASTERS; k++) begin
                int j;
                j = (int'(rr_ptr_q) + k) % NO_OF_MASTERS;
                if (!found_s && elig_s[j]) begin
                    win_idx_s = MW'(j);
                    found_s   = 1'b1;
                end
            end
        end
    end

    // Burst beat counter, only advanced by the granted master's own completed address phases.
    always_comb begin
        beats_left_d = beats_left_q;
        if (HREADY && (hmaster_q == grant_idx_s)) begin
            if (HRESP != 2'b00) begin
                beats_left_d = 4'd0;
            end else begin
                case (HTRANS)
                    2'b10: begin
                        case (HBURST)
                            3'd2, 3'd3: beats_left_d = 4'd3;
                            3'd4, 3'd5: beats_left_d = 4'd7;
                            3'd6, 3'd7: beats_left_d = 4'd15;
                            default:    beats_left_d = 4'd0;
                        endcase
                    end
                    2'b11:   beats_left_d = (beats_left_q != 4'd0) ? beats_left_q - 4'd1 : 4'd0;
                    2'b00:   beats_left_d = 4'd0;
                    default: beats_left_d = beats_left_q;
                endcase
            end
        end else begin
            beats_left_d = beats_left_q;
        end
    end

    // A split master loses its lock hold so it cannot starve the bus.
    always_comb begin
        hold_s  = (HLOCK[grant_idx_s] && !split_mask_q[grant_idx_s]) || (beats_left_d > 4'd1);
        rearb_s = HREADY && !hold_s;
        if (rearb_s) begin
            grant_d = NO_OF_MASTERS'(1) << win_idx_s;
        end else begin
            grant_d = grant_q;
        end
    end

    // Grant, owner, lock and round-robin pointer registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q      <= DEF_ONEHOT;
            hmaster_q    <= DEF_IDX;
            hmastlock_q  <= 1'b0;
            rr_ptr_q     <= DEF_IDX;
            beats_left_q <= 4'd0;
        end else begin
            grant_q      <= grant_d;
            beats_left_q <= beats_left_d;
            if (rearb_s && (grant_d != grant_q)) begin
                rr_ptr_q <= win_idx_s;
            end
            if (HREADY) begin
                hmaster_q   <= grant_idx_s;
                hmastlock_q <= HLOCK[grant_idx_s];
            end
        end
    end

`ifdef AHB_ARB_SPLIT_EN
    logic [NO_OF_MASTERS-1:0] split_mask_d;

    // Resume bits clear after the set so a same-cycle resume wins.
    always_comb begin
        split_mask_d = split_mask_q;
        if (HREADY && (HRESP == 2'b11)) begin
            split_mask_d[hmaster_q] = 1'b1;
        end else begin
            split_mask_d = split_mask_q;
        end
        split_mask_d = split_mask_d & ~HSPLIT;
    end

    // Split mask register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            split_mask_q <= '0;
        end else begin
            split_mask_q <= split_mask_d;
        end
    end
`else
    logic unused_hsplit_s;
    assign split_mask_q    = '0;
    assign unused_hsplit_s = ^HSPLIT;
`endif

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Table-driven scoreboard bench for ahb_arbiter_param: a round-robin and a fixed-priority instance share stimulus.
module tb_ahb_arbiter_param;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] split;
        logic       ready;
        logic [1:0] trans;
        logic [2:0] burst;
        logic [1:0] resp;
        logic [3:0] e_grant;
        logic [1:0] e_mst;
        logic       e_mlk;
        logic       fp_chk;
        logic [3:0] e_fp;
    } vec_t;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] HBUSREQ, HLOCK, HSPLIT;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic [1:0] HRESP;
    logic [3:0] grant_rr, grant_fp;
    logic [1:0] master_rr, master_fp_unused;
    logic       mlock_rr, mlock_fp_unused;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 HCLK = ~HCLK;

    ahb_arbiter_param #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(1)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
        .HREADY(HREADY), .HTRANS(HTRANS), .HBURST(HBURST), .HRESP(HRESP),
        .HGRANT(grant_rr), .HMASTER(master_rr), .HMASTLOCK(mlock_rr));

    ahb_arbiter_param #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(0)) dut_fp (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
        .HREADY(HREADY), .HTRANS(HTRANS), .HBURST(HBURST), .HRESP(HRESP),
        .HGRANT(grant_fp), .HMASTER(master_fp_unused), .HMASTLOCK(mlock_fp_unused));

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                                input logic [3:0] split, input logic ready, input logic [1:0] trans,
                                input logic [2:0] burst, input logic [1:0] resp,
                                input logic [3:0] eg, input logic [1:0] em, input logic el,
                                input logic fc, input logic [3:0] ef);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.split = split; v.ready = ready;
        v.trans = trans; v.burst = burst; v.resp = resp;
        v.e_grant = eg; v.e_mst = em; v.e_mlk = el; v.fp_chk = fc; v.e_fp = ef;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int n);
        vec_t e;
        @(negedge HCLK);
        HRESET = v.rst; HBUSREQ = v.req; HLOCK = v.lock; HSPLIT = v.split; HREADY = v.ready;
        HTRANS = v.trans; HBURST = v.burst; HRESP = v.resp;
        sb.push_back(v);
        @(posedge HCLK);
        #1;
        e = sb.pop_front();
        checks++;
        if (grant_rr !== e.e_grant) begin
            failures++;
            $display("FAIL %s[%0d] rr_grant got=%b exp=%b", tag, n, grant_rr, e.e_grant);
        end
        checks++;
        if (master_rr !== e.e_mst) begin
            failures++;
            $display("FAIL %s[%0d] rr_master got=%0d exp=%0d", tag, n, master_rr, e.e_mst);
        end
        checks++;
        if (mlock_rr !== e.e_mlk) begin
            failures++;
            $display("FAIL %s[%0d] rr_mastlock got=%b exp=%b", tag, n, mlock_rr, e.e_mlk);
        end
        if (e.fp_chk) begin
            checks++;
            if (grant_fp !== e.e_fp) begin
                failures++;
                $display("FAIL %s[%0d] fp_grant got=%b exp=%b", tag, n, grant_fp, e.e_fp);
            end
        end
    endtask

    initial begin
        HRESET = 1'b1; HBUSREQ = 4'b0000; HLOCK = 4'b0000; HSPLIT = 4'b0000; HREADY = 1'b1;
        HTRANS = 2'b00; HBURST = 3'd0; HRESP = 2'b00;

        // rst  req      lock     split    rdy   trans  burst resp    grant    mst   mlk   fpchk fp
        // Reset held two cycles while everyone requests
        vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001));
        // Round robin rotation with single transfers; fixed priority keeps master 0
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd0, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0100, 2'd1, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b1000, 2'd2, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0001, 2'd3, 1'b0, 1'b1, 4'b0001));
        // Masters 1 and 3: fixed priority stays on 1, round robin alternates
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd0, 1'b0, 1'b1, 4'b0010));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b1000, 2'd1, 1'b0, 1'b1, 4'b0010));
        vecs.push_back(mk(1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd3, 1'b0, 1'b1, 4'b0010));
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b1000, 2'd1, 1'b0, 1'b1, 4'b1000));
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b1000, 2'd3, 1'b0, 1'b1, 4'b1000));
        // INCR4 from master 2 with a wait state on beat 2
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0100, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd3, 2'b00, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'b11, 3'd3, 2'b00, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'b11, 3'd3, 2'b00, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'b11, 3'd3, 2'b00, 4'b0001, 2'd2, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'b11, 3'd3, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000));
        // Locked sequence by master 1, then release and an idle bus
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0010, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1011, 4'b0010, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1011, 4'b0010, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1011, 4'b0010, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1011, 4'b0010, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b1000, 2'd1, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd3, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000));
        // Split response to master 3, then HSPLIT[3] resume
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b1000, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b1000, 2'd3, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b1000, 2'd3, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b11, 4'b0001, 2'd3, 1'b0, 1'b0, 4'b0000));
`ifdef AHB_ARB_SPLIT_EN
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b1000, 2'd0, 1'b0, 1'b0, 4'b0000));
`else
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b1000, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd3, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b1000, 2'd0, 1'b0, 1'b0, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd3, 1'b0, 1'b0, 4'b0000));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], "table", i);
        end

        // Reset in the middle of an INCR4 must clear the beat counter
        apply(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001), "rst_burst", 0);
        apply(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0100, 2'd0, 1'b0, 1'b0, 4'b0000), "rst_burst", 1);
        apply(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000), "rst_burst", 2);
        apply(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd3, 2'b00, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0000), "rst_burst", 3);
        apply(mk(1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'b11, 3'd3, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001), "rst_burst", 4);
        apply(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'b11, 3'd3, 2'b00, 4'b0100, 2'd0, 1'b0, 1'b0, 4'b0000), "rst_burst", 5);

        // Lock held through a wait state keeps owner and lock flag steady
        apply(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0001), "lock_wait", 0);
        apply(mk(1'b0, 4'b0110, 4'b0010, 4'b0000, 1'b1, 2'b00, 3'd0, 2'b00, 4'b0010, 2'd0, 1'b0, 1'b0, 4'b0000), "lock_wait", 1);
        apply(mk(1'b0, 4'b0110, 4'b0010, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000), "lock_wait", 2);
        apply(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'b10, 3'd0, 2'b00, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000), "lock_wait", 3);
        apply(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'b10, 3'd0, 2'b00, 4'b0100, 2'd1, 1'b0, 1'b0, 4'b0000), "lock_wait", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
